// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: the ID-stage instruction fields, the pipeline
// control strobes (flush/freeze), and the stall outputs back to IF/ID.
interface hazard_scoreboard_if;
   logic [3:0]  SRC1;
   logic [3:0]  SRC2;
   logic        Two_SRC;
   logic [3:0]  Cond;
   logic        WB_EN;
   logic        MEM_R_EN;
   logic        S;
   logic [3:0]  Dest;
   logic        flush;
   logic        freeze;
   logic        hazard;
   logic [1:0]  hazard_cause;
   logic [15:0] stall_count;

   // Pipeline side: presents the ID instruction and consumes the stall request.
   modport master (
      output SRC1, SRC2, Two_SRC, Cond, WB_EN, MEM_R_EN, S, Dest, flush, freeze,
      input  hazard, hazard_cause, stall_count
   );

   // Scoreboard side.
   modport slave (
      input  SRC1, SRC2, Two_SRC, Cond, WB_EN, MEM_R_EN, S, Dest, flush, freeze,
      output hazard, hazard_cause, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline. Shadows the EXE, MEM and WB
// control/destination fields and raises a combinational stall when the ID
// instruction reads a register still in flight (RAW) or needs flags that the
// instruction in EXE has not yet written. Counts stall cycles, saturating.
module hazard_scoreboard #(
   parameter bit FORWARD_EN = 1'b0
) (
   input logic               clk,
   input logic               rst,
   hazard_scoreboard_if.slave sb
);

   localparam logic [3:0]  COND_AL = 4'b1110;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic       wb_en;
      logic       mem_r_en;
      logic       s;
      logic [3:0] dest;
   } slot_t;

   // slot_p0 = EXE, slot_p1 = MEM, slot_p2 = WB
   slot_t       slot_p0;
   slot_t       slot_p1;
   slot_t       slot_p2;
   slot_t       id_slot;
   logic [15:0] stall_cnt;
   logic        match_p0;
   logic        match_p1;
   logic        match_p2;
   logic        raw;
   logic        flag;
   logic        flush_eff;
   logic        hazard_int;
   logic [1:0]  cause_int;

   // Only wb_en/dest of MEM and WB take part in hazard detection.
   logic        unused_slot_bits;
   assign unused_slot_bits = ^{slot_p1.mem_r_en, slot_p1.s, slot_p2.mem_r_en, slot_p2.s};

   // A slot is a producer for this source set when it writes back to one of them.
   function automatic logic src_match(slot_t sl, logic [3:0] s1, logic [3:0] s2, logic two);
      return sl.wb_en && ((sl.dest == s1) || (two && (sl.dest == s2)));
   endfunction

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + 16'd1;
   endfunction

   assign id_slot = {sb.WB_EN, sb.MEM_R_EN, sb.S, sb.Dest};

   // Hazard detection: RAW against in-flight producers, flag hazard against EXE.
   always_comb begin
      match_p0 = src_match(slot_p0, sb.SRC1, sb.SRC2, sb.Two_SRC);
      match_p1 = src_match(slot_p1, sb.SRC1, sb.SRC2, sb.Two_SRC);
      match_p2 = src_match(slot_p2, sb.SRC1, sb.SRC2, sb.Two_SRC);
      raw      = 1'b0;
      if (FORWARD_EN) begin
         // With forwarding only a load in EXE cannot supply its result in time.
         raw = match_p0 && slot_p0.mem_r_en;
      end else begin
         // Register file writes in WB are not readable in the same cycle.
         raw = match_p0 || match_p1 || match_p2;
      end
      flag       = (sb.Cond != COND_AL) && slot_p0.s;
      // A flush while frozen is ignored, so it cannot mask the stall either.
      flush_eff  = sb.flush && !sb.freeze;
      hazard_int = !flush_eff && (raw || flag);
      cause_int  = flush_eff ? 2'b00 : {flag, raw};
   end

   // Shadow pipeline: shift on every unfrozen edge, bubble EXE on stall or flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_p0 <= '0;
         slot_p1 <= '0;
         slot_p2 <= '0;
      end else if (!sb.freeze) begin
         slot_p2 <= slot_p1;
         slot_p1 <= slot_p0;
         slot_p0 <= (sb.flush || hazard_int) ? slot_t'('0) : id_slot;
      end
   end

   // Stall cycle counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (hazard_int && !sb.freeze) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign sb.hazard       = hazard_int;
   assign sb.hazard_cause = cause_int;
   assign sb.stall_count  = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance without and one with forwarding,
// both fed the same ID stream, checked by directed scenarios and a random run
// against a stage-array reference model.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] src1, src2, cond, dest;
   logic       two_src, wb_en, mem_r_en, s_bit, flush, freeze;

   hazard_scoreboard_if if0 ();
   hazard_scoreboard_if if1 ();

   assign if0.SRC1 = src1;       assign if1.SRC1 = src1;
   assign if0.SRC2 = src2;       assign if1.SRC2 = src2;
   assign if0.Two_SRC = two_src; assign if1.Two_SRC = two_src;
   assign if0.Cond = cond;       assign if1.Cond = cond;
   assign if0.WB_EN = wb_en;     assign if1.WB_EN = wb_en;
   assign if0.MEM_R_EN = mem_r_en; assign if1.MEM_R_EN = mem_r_en;
   assign if0.S = s_bit;         assign if1.S = s_bit;
   assign if0.Dest = dest;       assign if1.Dest = dest;
   assign if0.flush = flush;     assign if1.flush = flush;
   assign if0.freeze = freeze;   assign if1.freeze = freeze;

   hazard_scoreboard #(.FORWARD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .sb(if0));
   hazard_scoreboard #(.FORWARD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .sb(if1));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pipe[cfg][0..2] = EXE, MEM, WB for cfg 0 (no fwd) / 1 (fwd).
   typedef struct { bit wb; bit mr; bit s; bit [3:0] d; } mslot_t;
   mslot_t      pipe [2][3];
   int unsigned mcnt [2];

   function automatic void model_eval(input int cfg, output bit hz, output bit [1:0] cause);
      bit raw;
      bit flg;
      raw = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bit reads;
         bit relevant;
         reads    = (pipe[cfg][k].d == src1) || (two_src && (pipe[cfg][k].d == src2));
         relevant = (cfg == 0) || ((k == 0) && pipe[cfg][k].mr);
         if (pipe[cfg][k].wb && reads && relevant) raw = 1'b1;
      end
      flg = (cond != 4'b1110) && pipe[cfg][0].s;
      if (flush && !freeze) begin
         hz = 1'b0; cause = 2'b00;
      end else begin
         hz = raw | flg; cause = {flg, raw};
      end
   endfunction

   task automatic model_step();
      bit       hz;
      bit [1:0] c;
      for (int cfg = 0; cfg < 2; cfg++) begin
         model_eval(cfg, hz, c);
         if (rst) begin
            for (int k = 0; k < 3; k++) pipe[cfg][k] = '{1'b0, 1'b0, 1'b0, 4'd0};
            mcnt[cfg] = 0;
         end else if (!freeze) begin
            pipe[cfg][2] = pipe[cfg][1];
            pipe[cfg][1] = pipe[cfg][0];
            if (flush || hz) pipe[cfg][0] = '{1'b0, 1'b0, 1'b0, 4'd0};
            else             pipe[cfg][0] = '{wb_en, mem_r_en, s_bit, dest};
            if (hz && mcnt[cfg] < 65535) mcnt[cfg] = mcnt[cfg] + 1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [3:0] a, input logic [3:0] b, input logic t,
                         input logic [3:0] c, input logic w, input logic m,
                         input logic sf, input logic [3:0] d);
      src1 = a; src2 = b; two_src = t; cond = c;
      wb_en = w; mem_r_en = m; s_bit = sf; dest = d;
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; freeze = 1'b0;
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; freeze = 1'b0;
      set_id(4'd3, 4'd5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'd3);
      tick();
      tick();
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hz0: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.hazard_cause !== 2'b00) begin n_fail++; $display("FAIL rst_cause0: got %b want 00", if0.hazard_cause); end
      n_checks++; if (if0.stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_cnt0: got %h want 0000", if0.stall_count); end
      n_checks++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hz1: got %0b want 0", if1.hazard); end
      n_checks++; if (if1.stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_cnt1: got %h want 0000", if1.stall_count); end
      rst = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_raw_nofwd();
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd3);
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL add_issue_hz: got %0b want 0", if0.hazard); end
      tick();
      set_id(4'd3, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL raw_hz stage%0d: got %0b want 1", i, if0.hazard); end
         n_checks++; if (if0.hazard_cause !== 2'b01) begin n_fail++; $display("FAIL raw_cause stage%0d: got %b want 01", i, if0.hazard_cause); end
         n_checks++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_fwd_hz stage%0d: got %0b want 0", i, if1.hazard); end
         tick();
      end
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.stall_count !== 16'd3) begin n_fail++; $display("FAIL raw_cnt0: got %0d want 3", if0.stall_count); end
      n_checks++; if (if1.stall_count !== 16'd0) begin n_fail++; $display("FAIL raw_cnt1: got %0d want 0", if1.stall_count); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b1, 1'b0, 4'd5);
      tick();
      set_id(4'd0, 4'd5, 1'b1, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++; if (if1.hazard !== 1'b1) begin n_fail++; $display("FAIL ldu_hz1: got %0b want 1", if1.hazard); end
      n_checks++; if (if1.hazard_cause !== 2'b01) begin n_fail++; $display("FAIL ldu_cause1: got %b want 01", if1.hazard_cause); end
      n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL ldu_hz0: got %0b want 1", if0.hazard); end
      tick();
      n_checks++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL ldu_release1: got %0b want 0", if1.hazard); end
      n_checks++; if (if1.stall_count !== 16'd1) begin n_fail++; $display("FAIL ldu_cnt1: got %0d want 1", if1.stall_count); end
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b1, 1'b0, 4'd5);
      tick();
      set_id(4'd0, 4'd5, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL ldu_one_src_hz1: got %0b want 0", if1.hazard); end
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL ldu_one_src_hz0: got %0b want 0", if0.hazard); end
      tick();
   endtask

   task automatic test_flag();
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b1, 4'd0);
      tick();
      set_id(4'd0, 4'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL flag_hz0: got %0b want 1", if0.hazard); end
      n_checks++; if (if0.hazard_cause !== 2'b10) begin n_fail++; $display("FAIL flag_cause0: got %b want 10", if0.hazard_cause); end
      n_checks++; if (if1.hazard_cause !== 2'b10) begin n_fail++; $display("FAIL flag_cause1: got %b want 10", if1.hazard_cause); end
      tick();
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL flag_release: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.stall_count !== 16'd1) begin n_fail++; $display("FAIL flag_cnt0: got %0d want 1", if0.stall_count); end
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b1, 4'd0);
      tick();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL flag_always_hz: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.hazard_cause !== 2'b00) begin n_fail++; $display("FAIL flag_always_cause: got %b want 00", if0.hazard_cause); end
      tick();
   endtask

   task automatic test_freeze();
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd3);
      tick();
      set_id(4'd3, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL frz_hz cyc%0d: got %0b want 1", i, if0.hazard); end
         n_checks++; if (if0.stall_count !== 16'd1) begin n_fail++; $display("FAIL frz_cnt cyc%0d: got %0d want 1", i, if0.stall_count); end
         tick();
      end
      freeze = 1'b0;
      #1;
      n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL frz_resume_hz: got %0b want 1", if0.hazard); end
      tick();
      n_checks++; if (if0.stall_count !== 16'd2) begin n_fail++; $display("FAIL frz_resume_cnt2: got %0d want 2", if0.stall_count); end
      n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL frz_wb_hz: got %0b want 1", if0.hazard); end
      tick();
      n_checks++; if (if0.stall_count !== 16'd3) begin n_fail++; $display("FAIL frz_resume_cnt3: got %0d want 3", if0.stall_count); end
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL frz_release: got %0b want 0", if0.hazard); end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd3);
      tick();
      flush = 1'b1;
      set_id(4'd3, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd7);
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL flush_hz: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.hazard_cause !== 2'b00) begin n_fail++; $display("FAIL flush_cause: got %b want 00", if0.hazard_cause); end
      tick();
      flush = 1'b0;
      set_id(4'd7, 4'd0, 1'b0, 4'he, 1'b0, 1'b0, 1'b0, 4'd0);
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL flush_bubble_hz: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.stall_count !== 16'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", if0.stall_count); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      force dut0.stall_cnt = 16'hFFFC;
      #1;
      release dut0.stall_cnt;
      set_id(4'd0, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd3);
      tick();
      set_id(4'd3, 4'd0, 1'b0, 4'he, 1'b1, 1'b0, 1'b0, 4'd3);
      tick();
      tick();
      n_checks++; if (if0.stall_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", if0.stall_count); end
      tick();
      n_checks++; if (if0.stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", if0.stall_count); end
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL sat_gap_hz: got %0b want 0", if0.hazard); end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL sat_hz cyc%0d: got %0b want 1", i, if0.hazard); end
         tick();
         n_checks++; if (if0.stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold cyc%0d: got %h want ffff", i, if0.stall_count); end
      end
      tick();
      n_checks++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL sat_pre_rst_hz: got %0b want 1", if0.hazard); end
      rst = 1'b1;
      tick();
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL midstall_rst_hz: got %0b want 0", if0.hazard); end
      n_checks++; if (if0.hazard_cause !== 2'b00) begin n_fail++; $display("FAIL midstall_rst_cause: got %b want 00", if0.hazard_cause); end
      n_checks++; if (if0.stall_count !== 16'd0) begin n_fail++; $display("FAIL sat_rst_cnt: got %h want 0000", if0.stall_count); end
      rst = 1'b0;
      #1;
      n_checks++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_slots_clear: got %0b want 0", if0.hazard); end
      tick();
   endtask

   task automatic test_random();
      bit       e_hz0, e_hz1;
      bit [1:0] e_c0, e_c1;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         src1     = 4'($urandom_range(0, 3));
         src2     = 4'($urandom_range(0, 3));
         two_src  = 1'($urandom);
         cond     = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom_range(0, 15));
         wb_en    = 1'($urandom);
         mem_r_en = 1'($urandom);
         s_bit    = ($urandom_range(0, 3) == 0);
         dest     = 4'($urandom_range(0, 3));
         freeze   = ($urandom_range(0, 6) == 0);
         flush    = !freeze && ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         #1;
         model_eval(0, e_hz0, e_c0);
         model_eval(1, e_hz1, e_c1);
         n_checks++; if (if0.hazard !== e_hz0) begin n_fail++; $display("FAIL rnd_hz0 #%0d: got %0b want %0b", n, if0.hazard, e_hz0); end
         n_checks++; if (if0.hazard_cause !== e_c0) begin n_fail++; $display("FAIL rnd_cause0 #%0d: got %b want %b", n, if0.hazard_cause, e_c0); end
         n_checks++; if (if0.stall_count !== 16'(mcnt[0])) begin n_fail++; $display("FAIL rnd_cnt0 #%0d: got %0d want %0d", n, if0.stall_count, mcnt[0]); end
         n_checks++; if (if1.hazard !== e_hz1) begin n_fail++; $display("FAIL rnd_hz1 #%0d: got %0b want %0b", n, if1.hazard, e_hz1); end
         n_checks++; if (if1.hazard_cause !== e_c1) begin n_fail++; $display("FAIL rnd_cause1 #%0d: got %b want %b", n, if1.hazard_cause, e_c1); end
         n_checks++; if (if1.stall_count !== 16'(mcnt[1])) begin n_fail++; $display("FAIL rnd_cnt1 #%0d: got %0d want %0d", n, if1.stall_count, mcnt[1]); end
         tick();
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 3; k++) pipe[c][k] = '{1'b0, 1'b0, 1'b0, 4'd0};
         mcnt[c] = 0;
      end
      rst = 1'b1;
      idle();
      test_reset();
      test_raw_nofwd();
      test_load_use();
      test_flag();
      test_freeze();
      test_flush();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
